pc_fetch_sequencer: RTL and testbench

- Consumes the branch decision (branch flag plus targets) produced by the branch-resolution logic and closes the loop back to instruction fetch.
- Holds the architectural PC and runs a req/ack handshake with instruction memory.
- Presents the fetched instruction to decode, then selects the next PC (PC+4, branch/JAL target, or JALR target).
- Traps on misaligned next-PC.

---
 rtl/pc_fetch_sequencer_if.sv | 23 ++
 rtl/pc_fetch_sequencer.sv | 98 +++++++++
 tb/tb_pc_fetch_sequencer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_sequencer_if.sv
// rtl/pc_fetch_sequencer_if.sv - instruction memory req/ack fetch interface
interface pc_fetch_sequencer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  Imem_Req_o;
    logic [DATA_WIDTH-1:0] Imem_Addr_o;
    logic                  Imem_Ack_i;
    logic [DATA_WIDTH-1:0] Instr_i;

    modport master (
        output Imem_Req_o,
        output Imem_Addr_o,
        input  Imem_Ack_i,
        input  Instr_i
    );

    modport slave (
        input  Imem_Req_o,
        input  Imem_Addr_o,
        output Imem_Ack_i,
        output Instr_i
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// rtl/pc_fetch_sequencer.sv - PC register, fetch handshake and next-PC selection with misalignment trap
module pc_fetch_sequencer #(
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0040_0000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  Branch_Flag_i,
    input  logic                  Jalr_i,
    input  logic [DATA_WIDTH-1:0] Branch_Target_i,
    input  logic [DATA_WIDTH-1:0] Jalr_Target_i,
    input  logic                  Stall_i,
    pc_fetch_sequencer_if.master  imem,
    output logic [DATA_WIDTH-1:0] Instr_o,
    output logic                  Instr_Valid_o,
    output logic [DATA_WIDTH-1:0] PC_o,
    output logic [DATA_WIDTH-1:0] PC_Plus_4_o,
    output logic                  Misaligned_o,
    output logic [DATA_WIDTH-1:0] Misaligned_Addr_o
);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {BOOT, REQ, EXEC, TRAP} state_t;

    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] pc, pc_n;
    logic [DATA_WIDTH-1:0] instr, instr_n;
    logic                  mis, mis_n;
    logic [DATA_WIDTH-1:0] mis_addr, mis_addr_n;
    logic [DATA_WIDTH-1:0] pc_plus_4;
    logic [DATA_WIDTH-1:0] next_pc;

    assign pc_plus_4 = pc + DATA_WIDTH'(4);

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= BOOT;
            pc       <= RESET_VECTOR;
            instr    <= NOP;
            mis      <= 1'b0;
            mis_addr <= '0;
        end else begin
            state    <= state_n;
            pc       <= pc_n;
            instr    <= instr_n;
            mis      <= mis_n;
            mis_addr <= mis_addr_n;
        end
    end

    always_comb begin
        state_n    = state;
        pc_n       = pc;
        instr_n    = instr;
        mis_n      = mis;
        mis_addr_n = mis_addr;
        next_pc    = pc_plus_4;

        // JALR beats a plain branch target; its bit 0 is always dropped.
        if (Branch_Flag_i && Jalr_i)
            next_pc = {Jalr_Target_i[DATA_WIDTH-1:1], 1'b0};
        else if (Branch_Flag_i)
            next_pc = Branch_Target_i;

        case (state)
            BOOT: state_n = REQ;
            REQ: begin
                if (imem.Imem_Ack_i) begin
                    instr_n = imem.Instr_i;
                    state_n = EXEC;
                end
            end
            EXEC: begin
                if (!Stall_i) begin
                    if (next_pc[1:0] == 2'b00) begin
                        pc_n    = next_pc;
                        state_n = REQ;
                    end else begin
                        mis_n      = 1'b1;
                        mis_addr_n = next_pc;
                        state_n    = TRAP;
                    end
                end
            end
            TRAP: state_n = TRAP;
            default: state_n = BOOT;
        endcase
    end

    assign imem.Imem_Req_o   = (state == REQ);
    assign imem.Imem_Addr_o  = pc;
    assign Instr_o           = instr;
    assign Instr_Valid_o     = (state == EXEC);
    assign PC_o              = pc;
    assign PC_Plus_4_o       = pc_plus_4;
    assign Misaligned_o      = mis;
    assign Misaligned_Addr_o = mis_addr;
endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// tb/tb_pc_fetch_sequencer.sv - randomized self-checking bench with transaction-level PC model
module tb_pc_fetch_sequencer;
    localparam logic [31:0] RV   = 32'h0040_0000;
    localparam logic [31:0] RV2  = 32'hFFFF_FFFC;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic        bf, jalr, stall;
    logic [31:0] bt, jt;
    logic [31:0] instr_o, pc_o, pc4_o, maddr_o;
    logic        valid_o, mis_o;
    logic [31:0] instr2_o, pc2_o, pc42_o, maddr2_o;
    logic        valid2_o, mis2_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_pc, m_instr, m_maddr;
    logic        m_trap;

    always #5 clk = ~clk;

    pc_fetch_sequencer_if #(.DATA_WIDTH(32)) imem ();
    pc_fetch_sequencer_if #(.DATA_WIDTH(32)) imem2 ();

    assign imem2.Imem_Ack_i = imem.Imem_Ack_i;
    assign imem2.Instr_i    = imem.Instr_i;

    pc_fetch_sequencer #(.DATA_WIDTH(32), .RESET_VECTOR(RV)) dut (
        .clk(clk), .reset(reset), .Branch_Flag_i(bf), .Jalr_i(jalr),
        .Branch_Target_i(bt), .Jalr_Target_i(jt), .Stall_i(stall), .imem(imem),
        .Instr_o(instr_o), .Instr_Valid_o(valid_o), .PC_o(pc_o), .PC_Plus_4_o(pc4_o),
        .Misaligned_o(mis_o), .Misaligned_Addr_o(maddr_o)
    );

    pc_fetch_sequencer #(.DATA_WIDTH(32), .RESET_VECTOR(RV2)) dut2 (
        .clk(clk), .reset(reset), .Branch_Flag_i(bf), .Jalr_i(jalr),
        .Branch_Target_i(bt), .Jalr_Target_i(jt), .Stall_i(stall), .imem(imem2),
        .Instr_o(instr2_o), .Instr_Valid_o(valid2_o), .PC_o(pc2_o), .PC_Plus_4_o(pc42_o),
        .Misaligned_o(mis2_o), .Misaligned_Addr_o(maddr2_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pc    = RV;
        m_instr = NOP;
        m_trap  = 1'b0;
        m_maddr = 32'h0;
    endtask

    task automatic check_boot();
        check("boot_req",   {31'b0, imem.Imem_Req_o}, 32'd0);
        check("boot_valid", {31'b0, valid_o}, 32'd0);
        check("boot_pc",    pc_o, RV);
        check("boot_instr", instr_o, NOP);
        check("boot_mis",   {31'b0, mis_o}, 32'd0);
        check("boot_maddr", maddr_o, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem.Imem_Ack_i = 1'b0;
        imem.Instr_i = $urandom;
        stall = 1'b0; bf = 1'b0; jalr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        model_reset();
        check_boot();
        reset = 1'b0;
    endtask

    task automatic fetch(input int waits, input logic [31:0] word);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            check("req",       {31'b0, imem.Imem_Req_o}, 32'd1);
            check("addr",      imem.Imem_Addr_o, m_pc);
            check("req_valid", {31'b0, valid_o}, 32'd0);
            check("req_instr", instr_o, m_instr);
            check("req_mis",   {31'b0, mis_o}, 32'd0);
            stall = $urandom; bf = $urandom; jalr = $urandom;
            bt = $urandom; jt = $urandom;
            imem.Imem_Ack_i = (i == waits);
            imem.Instr_i    = (i == waits) ? word : $urandom;
        end
        m_instr = word;
    endtask

    task automatic execute(input int stalls, input logic b, input logic j,
                           input logic [31:0] btgt, input logic [31:0] jtgt);
        logic [31:0] nxt;
        for (int i = 0; i <= stalls; i++) begin
            @(negedge clk);
            check("ex_valid", {31'b0, valid_o}, 32'd1);
            check("ex_req",   {31'b0, imem.Imem_Req_o}, 32'd0);
            check("ex_instr", instr_o, m_instr);
            check("ex_pc",    pc_o, m_pc);
            check("ex_pc4",   pc4_o, m_pc + 32'd4);
            imem.Imem_Ack_i = $urandom;
            imem.Instr_i    = $urandom;
            if (i < stalls) begin
                stall = 1'b1; bf = $urandom; jalr = $urandom;
                bt = $urandom; jt = $urandom;
            end else begin
                stall = 1'b0; bf = b; jalr = j; bt = btgt; jt = jtgt;
            end
        end
        if (b && j)  nxt = jtgt - (jtgt % 2);
        else if (b)  nxt = btgt;
        else         nxt = m_pc + 32'd4;
        if (nxt % 4 != 0) begin
            m_trap  = 1'b1;
            m_maddr = nxt;
        end else begin
            m_pc = nxt;
        end
    endtask

    task automatic check_trap(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("trap_req",   {31'b0, imem.Imem_Req_o}, 32'd0);
            check("trap_valid", {31'b0, valid_o}, 32'd0);
            check("trap_mis",   {31'b0, mis_o}, 32'd1);
            check("trap_maddr", maddr_o, m_maddr);
            check("trap_pc",    pc_o, m_pc);
            imem.Imem_Ack_i = $urandom; imem.Instr_i = $urandom;
            stall = $urandom; bf = $urandom; jalr = $urandom;
            bt = $urandom; jt = $urandom;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] bt_r, jt_r;
        bt = 0; jt = 0; bf = 0; jalr = 0; stall = 0;
        do_reset();

        fetch(0, 32'h1111_0001);
        check("rv2_addr0", imem2.Imem_Addr_o, RV2);
        execute(0, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rv2_pc4", pc42_o, 32'h0000_0000);
        fetch(0, 32'h2222_0002);
        check("rv2_addr1", imem2.Imem_Addr_o, 32'h0000_0000);
        execute(0, 1'b0, 1'b0, 32'h0, 32'h0);
        fetch(0, 32'h3333_0003);
        check("seq_addr2", imem.Imem_Addr_o, 32'h0040_0008);
        execute(0, 1'b1, 1'b0, 32'h0040_0100, 32'h0);
        fetch(0, 32'h4444_0004);
        check("br_addr", imem.Imem_Addr_o, 32'h0040_0100);
        execute(0, 1'b1, 1'b1, 32'h0040_0102, 32'h0040_0201);
        fetch(0, 32'h5555_0005);
        check("jalr_addr", imem.Imem_Addr_o, 32'h0040_0200);
        execute(0, 1'b1, 1'b0, 32'h0040_0102, 32'h0);
        check_trap(4);
        check("trap_addr_val", maddr_o, 32'h0040_0102);

        do_reset();
        fetch(3, 32'h6666_0006);
        execute(2, 1'b0, 1'b1, 32'h0, 32'h0);
        fetch(1, 32'h7777_0007);
        execute(0, 1'b0, 1'b0, 32'h0, 32'h0);

        @(negedge clk);
        check("rst_pre_req", {31'b0, imem.Imem_Req_o}, 32'd1);
        reset = 1'b1;
        imem.Imem_Ack_i = 1'b1;
        imem.Instr_i = 32'hDEAD_BEEF;
        @(negedge clk);
        check_boot();
        model_reset();
        reset = 1'b0;
        imem.Imem_Ack_i = 1'b0;

        for (int n = 0; n < 60; n++) begin
            bt_r = $urandom;
            if ($urandom_range(0, 7) != 0) bt_r[1:0] = 2'b00;
            jt_r = $urandom;
            if ($urandom_range(0, 7) != 0) jt_r[1] = 1'b0;
            fetch($urandom_range(0, 3), $urandom);
            execute($urandom_range(0, 2), 1'($urandom), 1'($urandom), bt_r, jt_r);
            if (m_trap) begin
                check_trap(2);
                do_reset();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
